// File: rtl/my_bcd.sv
// Registered BCD-to-seven-segment decoder, active-high segments a-g, 1-cycle latency.
// Define MY_BCD_HEX_EN to show hex glyphs A-F for codes 10-15 (otherwise they blank).
module my_bcd (
    input  logic clk,
    input  logic rst,
    input  logic in0,
    input  logic in1,
    input  logic in2,
    input  logic in3,
    output logic a,
    output logic b,
    output logic c,
    output logic d,
    output logic e,
    output logic f,
    output logic g
);

    logic [3:0] digit_s;
    logic [6:0] seg_d;
    logic [6:0] seg_q;

    // Segment pattern ordered {a,b,c,d,e,f,g}; unlisted codes blank the digit.
    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        logic [6:0] pat;
        case (n)
            4'd0:    pat = 7'b1111110;
            4'd1:    pat = 7'b0110000;
            4'd2:    pat = 7'b1101101;
            4'd3:    pat = 7'b1111001;
            4'd4:    pat = 7'b0110011;
            4'd5:    pat = 7'b1011011;
            4'd6:    pat = 7'b1011111;
            4'd7:    pat = 7'b1110000;
            4'd8:    pat = 7'b1111111;
            4'd9:    pat = 7'b1111011;
`ifdef MY_BCD_HEX_EN
            4'd10:   pat = 7'b1110111;
            4'd11:   pat = 7'b0011111;
            4'd12:   pat = 7'b1001110;
            4'd13:   pat = 7'b0111101;
            4'd14:   pat = 7'b1001111;
            4'd15:   pat = 7'b1000111;
`endif
            default: pat = 7'b0000000;
        endcase
        return pat;
    endfunction

    assign digit_s = {in3, in2, in1, in0};

    // Combinational decode of the current digit.
    always_comb begin
        seg_d = 7'b0000000;
        seg_d = seg_decode(digit_s);
    end

    // Output register; reset blanks the digit without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q <= 7'b0000000;
        end else begin
            seg_q <= seg_d;
        end
    end

    assign {a, b, c, d, e, f, g} = seg_q;

endmodule

// File: tb/tb_my_bcd.sv
// Self-checking bench for my_bcd: directed plan items plus randomized digits and reset pulses.
// Honours MY_BCD_HEX_EN to select the expected glyphs for codes 10-15.
`timescale 1ns/1ps
module tb_my_bcd;

    logic clk;
    logic rst;
    logic in0, in1, in2, in3;
    logic a, b, c, d, e, f, g;

    int checks;
    int errors;
    logic [6:0] glyph [16];
    logic [3:0] pend_q [$];

    my_bcd dut (
        .clk(clk), .rst(rst),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] segs();
        return {a, b, c, d, e, f, g};
    endfunction

    task automatic check_seg(input string tag, input logic [6:0] got, input logic [6:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic set_n(input logic [3:0] n);
        {in3, in2, in1, in0} = n;
    endtask

    // Apply n after a falling edge, then check the registered glyph just after the next rising edge.
    task automatic step(input string tag, input logic [3:0] n);
        logic [3:0] old;
        @(negedge clk);
        set_n(n);
        pend_q.push_back(n);
        @(posedge clk);
        #1;
        old = pend_q.pop_front();
        check_seg(tag, segs(), glyph[old]);
    endtask

    initial begin
        glyph[0] = 7'b1111110; glyph[1] = 7'b0110000; glyph[2] = 7'b1101101;
        glyph[3] = 7'b1111001; glyph[4] = 7'b0110011; glyph[5] = 7'b1011011;
        glyph[6] = 7'b1011111; glyph[7] = 7'b1110000; glyph[8] = 7'b1111111;
        glyph[9] = 7'b1111011;
`ifdef MY_BCD_HEX_EN
        glyph[10] = 7'b1110111; glyph[11] = 7'b0011111; glyph[12] = 7'b1001110;
        glyph[13] = 7'b0111101; glyph[14] = 7'b1001111; glyph[15] = 7'b1000111;
`else
        for (int i = 10; i < 16; i++) glyph[i] = 7'b0000000;
`endif
        checks = 0;
        errors = 0;

        // Reset with N=8: blank immediately and while held across edges.
        rst = 1'b1;
        set_n(4'd8);
        #1;
        check_seg("reset_init", segs(), 7'b0000000);
        @(posedge clk); @(posedge clk); #1;
        check_seg("reset_held", segs(), 7'b0000000);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check_seg("reset_release", segs(), 7'b1111111);

        // Sweep 0-15, one code per cycle.
        for (int i = 0; i < 16; i++) step($sformatf("sweep_%0d", i), 4'(i));

        // Latency: N=1, then change to 7 mid-cycle.
        step("lat_1", 4'd1);
        @(negedge clk);
        set_n(4'd7);
        #2;
        check_seg("lat_hold", segs(), 7'b0110000);
        @(posedge clk); #1;
        check_seg("lat_7", segs(), 7'b1110000);

        // Async reset between edges with 6 displayed.
        step("arst_6", 4'd6);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_seg("arst_blank", segs(), 7'b0000000);
        set_n(4'd3);
        #1;
        rst = 1'b0;
        #1;
        check_seg("arst_still_blank", segs(), 7'b0000000);
        @(posedge clk); #1;
        check_seg("arst_after", segs(), glyph[3]);

        // Boundary 9 -> 10.
        step("bound_9", 4'd9);
        step("bound_10", 4'd10);

        // Input isolation: toggle in0 between edges, ending on N=2.
        step("iso_pre", 4'd3);
        @(negedge clk);
        set_n(4'd2); #1; set_n(4'd3); #1; set_n(4'd2); #1; set_n(4'd3); #1;
        check_seg("iso_mid", segs(), glyph[3]);
        set_n(4'd2);
        @(posedge clk); #1;
        check_seg("iso_2", segs(), 7'b1101101);

        // Randomized digits with occasional mid-cycle reset pulses.
        for (int k = 0; k < 300; k++) begin
            logic [3:0] n;
            n = 4'($urandom_range(15, 0));
            if ($urandom_range(9, 0) == 0) begin
                @(negedge clk);
                rst = 1'b1;
                #1;
                check_seg("rnd_rst", segs(), 7'b0000000);
                rst = 1'b0;
            end
            step("rnd", n);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
